// File: rtl/muldiv_pkg.sv
// Shared types and Funct3 decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f3);
        return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 RV32M mul/div: done 34 cycles after accept (2 for divide by zero).
// busy stalls EX until done; start while busy is dropped, flush aborts at once.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      r_state, w_next;
    logic [CW-1:0]      r_count;
    logic [2:0]         r_f3;
    logic               r_sign_a, r_sign_b, r_dz;
    logic [WIDTH-1:0]   r_abs_a, r_abs_b, r_result;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_accept, w_sign_a, w_sign_b, w_div0, w_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_fix_result;
    logic [WIDTH:0]     w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_step, w_prod_fix;

    always_comb begin
        w_next       = r_state;
        w_sign_a     = a_signed(Funct3) & SrcA[WIDTH-1];
        w_sign_b     = b_signed(Funct3) & SrcB[WIDTH-1];
        w_abs_a      = w_sign_a ? -SrcA : SrcA;
        w_abs_b      = w_sign_b ? -SrcB : SrcB;
        w_div0       = is_div(Funct3) && (SrcB == '0);
        w_accept     = (r_state == IDLE) && start && !flush;

        // Product register: multiplier shifts out of the low half while the
        // partial sum enters the top. Divide keeps remainder high, quotient low.
        w_sum        = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_abs_a} : '0);
        w_shift      = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
        w_diff       = w_shift - {1'b0, r_abs_b};
        if (!is_div(r_f3))
            w_step = {w_sum, r_prod[WIDTH-1:1]};
        else if (!w_diff[WIDTH])
            w_step = {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
        else
            w_step = {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};

        w_neg        = r_sign_a ^ r_sign_b;
        w_prod_fix   = w_neg ? -r_prod : r_prod;
        w_quot       = r_dz ? '1 : (w_neg ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
        // Divide by zero returns the dividend untouched: re-apply its sign.
        w_rem        = r_dz ? (r_sign_a ? -r_abs_a : r_abs_a)
                            : (r_sign_a ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH]);
        case (r_f3)
            F3_MUL:                       w_fix_result = w_prod_fix[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod_fix[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:              w_fix_result = w_quot;
            default:                      w_fix_result = w_rem;
        endcase

        case (r_state)
            IDLE:    if (start) w_next = w_div0 ? FIX : CALC;
            CALC:    if (r_count == CW'(WIDTH-1)) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (flush)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_count <= '0;
            else if (r_state == CALC)
                r_count <= r_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f3     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dz     <= 1'b0;
            r_abs_a  <= '0;
            r_abs_b  <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_f3     <= Funct3;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_dz     <= w_div0;
                r_abs_a  <= w_abs_a;
                r_abs_b  <= w_abs_b;
                r_prod   <= is_div(Funct3) ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            end else if (r_state == CALC) begin
                r_prod   <= w_step;
            end
            if (r_state == FIX && !flush)
                r_result <= w_fix_result;
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign Result = r_result;

endmodule
